regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 instr_valid  in  1  instruction word offered.
REQ-004 instr  in  32  R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
REQ-005 instr_ready  out  1  high only in IDLE; transfer on valid&ready edge.
REQ-006 reg_rd_en  out  1  register-file read request.
REQ-007 reg_wr_en  out  1  register-file write strobe.
REQ-008 rs, rt  out  5 each  read addresses, valid while reg_rd_en high.
REQ-009 wr_reg  out  5  write address; wr_data  out  32  write data; both valid while reg_wr_en high.
REQ-010 dato_A, dato_B  in  32 each  register-file read data, valid one cycle after reg_rd_en.
REQ-011 done  out  1  one-cycle completion pulse; err  out  1  error status, valid with done; result  out  32  computed value, valid with done.

Function
REQ-012 Legal register indices: 0, 8-13; any other rs/rt/rd index is illegal.
REQ-013 States: IDLE, RD_REQ, RD_WAIT, EXEC, WR, DONE.
REQ-014 IDLE->RD_REQ on valid&ready; instr latched into internal register at that edge; otherwise hold IDLE.
REQ-015 RD_REQ: reg_rd_en=1, rs/rt driven from latched instr; unconditional ->RD_WAIT.
REQ-016 RD_WAIT: dato_A/dato_B captured into opA/opB at end of cycle; ->EXEC.
REQ-017 EXEC: result computed and registered; ->WR if write permitted, else ->DONE.
REQ-018 WR: reg_wr_en=1, wr_reg=rd, wr_data=result; ->DONE.
REQ-019 DONE: done=1 for exactly one cycle; ->IDLE.
REQ-020 Latency: accept at edge T; reg_rd_en during T+1; reg_wr_en during T+4; done during T+5 (T+4 when write skipped).
REQ-021 funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or; arithmetic 32-bit modulo, no overflow detection.
REQ-022 err=1 and write skipped when opcode != 0, funct unsupported, or any of rs/rt/rd illegal; read phase still executes.
REQ-023 rd=0 with legal operands: write skipped, err=0, result still reported.
REQ-024 reg_rd_en and reg_wr_en are never high in the same cycle; both low outside RD_REQ/WR.
REQ-025 instr_valid while not ready is ignored; next transfer no earlier than the cycle after DONE.
REQ-026 result, err, done and write outputs hold when not being driven active; done low otherwise.

Reset
REQ-027 rst high at any edge, including mid-operation: state=IDLE, reg_rd_en=0, reg_wr_en=0, done=0, err=0, result=0, rs=rt=wr_reg=0, wr_data=0; in-flight instruction discarded, no write issued.
REQ-028 instr_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro REGSEQ_SLT_EN: when defined, funct 0x2A (slt) supported, result = 1 if signed opA < signed opB else 0.
REQ-030 Without REGSEQ_SLT_EN: funct 0x2A treated as unsupported per REQ-022.

Verification
REQ-031 add rs=8(5), rt=9(7), rd=10 -> reg_wr_en at T+4, wr_reg=10, wr_data=12; done at T+5, err=0.
REQ-032 sub rs=0, rt=8(1), rd=11 -> wr_data=0xFFFFFFFF, err=0.
REQ-033 add with rd=0 -> no reg_wr_en, done at T+4, err=0; funct 0x27 -> no reg_wr_en, done with err=1.
REQ-034 slt rs=8(0xFFFFFFFF), rt=9(1), rd=12 -> wr_data=1 with REGSEQ_SLT_EN; err=1, no write without it.
REQ-035 rst asserted during WR cycle -> reg_wr_en low next cycle, no done, instr_ready=1 after release.
REQ-036 instr_valid held high continuously for two instructions -> second accepted only in IDLE after DONE; rd_en/wr_en never overlap.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle R-type sequencer with register-file handshakes; define REGSEQ_SLT_EN to support slt (funct 0x2A)
module regfile_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        reg_rd_en,
  output logic        reg_wr_en,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  input  logic [31:0] dato_A,
  input  logic [31:0] dato_B,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);
  localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_WAIT = 3'd2, EXEC = 3'd3, WR = 3'd4, DONE = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [5:0]  op_q, fn_q;
  logic [4:0]  rs_q, rt_q, rd_q, wr_reg_q;
  logic [31:0] opa_q, opb_q, result_q, alu;
  logic        err_q, slt_ok, funct_ok, bad, do_wr;
  logic        unused_shamt;
  function automatic logic legal(input logic [4:0] i);
    return i == 5'd0 || (i >= 5'd8 && i <= 5'd13);
  endfunction
  assign unused_shamt = ^instr[10:6];
`ifdef REGSEQ_SLT_EN
  assign slt_ok = 1'b1;
`else
  assign slt_ok = 1'b0;
`endif
  // operation decode, ALU and error classification for the latched instruction
  always_comb begin
    funct_ok = fn_q == 6'h20 || fn_q == 6'h22 || fn_q == 6'h24 || fn_q == 6'h25 || (slt_ok && fn_q == 6'h2A);
    alu = fn_q == 6'h20 ? opa_q + opb_q :
          fn_q == 6'h22 ? opa_q - opb_q :
          fn_q == 6'h24 ? opa_q & opb_q :
          fn_q == 6'h25 ? opa_q | opb_q :
          (slt_ok && fn_q == 6'h2A) ? {31'd0, $signed(opa_q) < $signed(opb_q)} : 32'd0;
    bad = op_q != 6'd0 || !funct_ok || !legal(rs_q) || !legal(rt_q) || !legal(rd_q);
    do_wr = !bad && rd_q != 5'd0;
  end
  // next-state sequencing; a skipped write goes straight from EXEC to DONE
  always_comb begin
    state_d = state_q == IDLE    ? (instr_valid ? RD_REQ : IDLE) :
              state_q == RD_REQ  ? RD_WAIT :
              state_q == RD_WAIT ? EXEC :
              state_q == EXEC    ? (do_wr ? WR : DONE) :
              state_q == WR      ? DONE : IDLE;
  end
  // state, instruction latch, operand capture and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      fn_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wr_reg_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) begin
        op_q <= instr[31:26];
        rs_q <= instr[25:21];
        rt_q <= instr[20:16];
        rd_q <= instr[15:11];
        fn_q <= instr[5:0];
      end
      if (state_q == RD_WAIT) begin
        opa_q <= dato_A;
        opb_q <= dato_B;
      end
      if (state_q == EXEC) begin
        result_q <= alu;
        err_q    <= bad;
        wr_reg_q <= rd_q;
      end
    end
  end
  assign instr_ready = state_q == IDLE;
  assign reg_rd_en   = state_q == RD_REQ;
  assign reg_wr_en   = state_q == WR;
  assign done        = state_q == DONE;
  assign rs          = rs_q;
  assign rt          = rt_q;
  assign wr_reg      = wr_reg_q;
  assign wr_data     = result_q;
  assign result      = result_q;
  assign err         = err_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: cycle-level model check of regfile_sequencer plus directed literal checks
module tb_regfile_sequencer;
  logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
  logic [31:0] instr = '0, dato_A = '0, dato_B = '0;
  logic        instr_ready, reg_rd_en, reg_wr_en, done, err;
  logic [4:0]  rs, rt, wr_reg;
  logic [31:0] wr_data, result;
  regfile_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
    .rs(rs), .rt(rt), .wr_reg(wr_reg), .wr_data(wr_data),
    .dato_A(dato_A), .dato_B(dato_B), .done(done), .err(err), .result(result)
  );
  always #5 clk = ~clk;
  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    return {op, s, t, d, 5'd0, f};
  endfunction
  function automatic bit legal(input logic [4:0] i);
    return i == 0 || (i >= 8 && i <= 13);
  endfunction
  logic [31:0] mem [32];
  int          wcnt = 0;
  logic [4:0]  last_reg = '0;
  logic [31:0] last_data = '0;
  // register file: read data one cycle after the request, writes logged
  always @(posedge clk) begin
    dato_A <= reg_rd_en ? mem[rs] : 32'hDEAD_BEEF;
    dato_B <= reg_rd_en ? mem[rt] : 32'hDEAD_BEEF;
    if (reg_wr_en) begin
      wcnt      <= wcnt + 1;
      last_reg  <= wr_reg;
      last_data <= wr_data;
    end
  end
  int          cyc = 0, k = 0, dk = 0;
  bit          busy = 0, armed = 0, ewr, eerr;
  logic [31:0] eres;
  logic [4:0]  ers, ert, erd;
  // transaction model: on acceptance compute the outcome and the cycle schedule
  always @(posedge clk) begin
    logic [31:0] a, b;
    logic [5:0]  f;
    bit          fok;
    cyc++;
    if (rst) begin
      busy = 0;
      armed = 1;
    end else if (busy) begin
      k++;
      if (k > dk) busy = 0;
    end else if (instr_valid) begin
      ers = instr[25:21]; ert = instr[20:16]; erd = instr[15:11]; f = instr[5:0];
      a = mem[ers]; b = mem[ert];
      fok = 1;
      if (f == 6'h20) eres = a + b;
      else if (f == 6'h22) eres = a - b;
      else if (f == 6'h24) eres = a & b;
      else if (f == 6'h25) eres = a | b;
`ifdef REGSEQ_SLT_EN
      else if (f == 6'h2A) eres = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`endif
      else begin fok = 0; eres = 0; end
      eerr = instr[31:26] != 0 || !fok || !legal(ers) || !legal(ert) || !legal(erd);
      ewr = !eerr && erd != 0;
      dk = ewr ? 5 : 4;
      k = 1;
      busy = 1;
    end
  end
  int rd_cyc = 0, rd_prev = 0, wr_cyc = 0, done_cyc = 0;
  logic done_err = 1'b0;
  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    bit er, ew, ed;
    if (armed) begin
      er = busy && k == 1;
      ew = busy && ewr && k == 4;
      ed = busy && k == dk;
      chk("instr_ready", instr_ready, !busy);
      chk("reg_rd_en", reg_rd_en, er);
      chk("reg_wr_en", reg_wr_en, ew);
      chk("done", done, ed);
      chk("rd_wr_overlap", reg_rd_en & reg_wr_en, 0);
      if (er) begin chk("rs", rs, ers); chk("rt", rt, ert); end
      if (ew) begin chk("wr_reg", wr_reg, erd); chk("wr_data", wr_data, eres); end
      if (ed) begin
        chk("err", err, eerr);
        if (!eerr) chk("result", result, eres);
      end
      if (reg_rd_en) begin rd_prev = rd_cyc; rd_cyc = cyc; end
      if (reg_wr_en) wr_cyc = cyc;
      if (done) begin done_cyc = cyc; done_err = err; end
    end
  end
  int acc, wc;
  task automatic run(input logic [31:0] w);
    @(negedge clk); instr = w; instr_valid = 1;
    @(negedge clk); instr_valid = 0; acc = cyc; wc = wcnt;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_rs_rt_wr", {rs, rt, wr_reg}, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1);
    mem[8] = 5; mem[9] = 7;
    run(enc(6'd0, 5'd8, 5'd9, 5'd10, 6'h20));
    chk("model_add", eres, 12);
    chk("add_wr_reg", last_reg, 10);
    chk("add_wr_data", last_data, 12);
    chk("add_wr_lat", wr_cyc - acc, 3);
    chk("add_done_lat", done_cyc - acc, 4);
    chk("add_err", done_err, 0);
    mem[8] = 1;
    run(enc(6'd0, 5'd0, 5'd8, 5'd11, 6'h22));
    chk("sub_wr_data", last_data, 32'hFFFF_FFFF);
    chk("sub_err", done_err, 0);
    mem[8] = 5;
    run(enc(6'd0, 5'd8, 5'd9, 5'd0, 6'h20));
    chk("rd0_no_write", wcnt, wc);
    chk("rd0_done_lat", done_cyc - acc, 3);
    chk("rd0_err", done_err, 0);
    chk("rd0_result", result, 12);
    run(enc(6'd0, 5'd8, 5'd9, 5'd10, 6'h27));
    chk("f27_no_write", wcnt, wc);
    chk("f27_err", done_err, 1);
    mem[8] = 32'hFFFF_FFFF; mem[9] = 1;
    run(enc(6'd0, 5'd8, 5'd9, 5'd12, 6'h2A));
`ifdef REGSEQ_SLT_EN
    chk("slt_wr_data", last_data, 1);
    chk("slt_wr_reg", last_reg, 12);
    chk("slt_err", done_err, 0);
`else
    chk("slt_no_write", wcnt, wc);
    chk("slt_err", done_err, 1);
`endif
    mem[8] = 32'hF0F0; mem[9] = 32'hFF00;
    run(enc(6'd0, 5'd8, 5'd9, 5'd13, 6'h24));
    chk("and_wr_data", last_data, 32'hF000);
    run(enc(6'd0, 5'd9, 5'd8, 5'd13, 6'h25));
    chk("or_wr_data", last_data, 32'hFFF0);
    run(enc(6'd0, 5'd1, 5'd9, 5'd10, 6'h20));
    chk("bad_rs_err", done_err, 1);
    chk("bad_rs_no_write", wcnt, wc);
    run(enc(6'd0, 5'd8, 5'd9, 5'd14, 6'h20));
    chk("bad_rd_err", done_err, 1);
    run(enc(6'd1, 5'd8, 5'd9, 5'd10, 6'h20));
    chk("bad_op_err", done_err, 1);
    chk("bad_op_no_write", wcnt, wc);
    @(negedge clk); instr = enc(6'd0, 5'd8, 5'd9, 5'd10, 6'h20); instr_valid = 1;
    @(negedge clk); instr_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_wr_active", reg_wr_en, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_wr_low", reg_wr_en, 0);
    chk("mid_done_low", done, 0);
    chk("mid_result", result, 0);
    rst = 0;
    @(negedge clk);
    chk("mid_ready", instr_ready, 1);
    chk("mid_no_done", done, 0);
    mem[8] = 2; mem[9] = 3;
    @(negedge clk); instr = enc(6'd0, 5'd8, 5'd9, 5'd10, 6'h20); instr_valid = 1;
    @(negedge clk); acc = cyc; instr = enc(6'd0, 5'd9, 5'd8, 5'd11, 6'h22);
    repeat (8) @(negedge clk);
    instr_valid = 0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", done, 1);
    @(negedge clk);
    chk("b2b_first_rd", rd_prev, acc);
    chk("b2b_gap", rd_cyc - rd_prev, 6);
    chk("b2b_wr_reg", last_reg, 11);
    chk("b2b_wr_data", last_data, 1);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
